// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS CP0 register file answering WB-stage requests (mtc0/mfc0,
// exception commit, eret, TLBP/TLBR results), with timer and interrupt detect.
// Optional TLB registers (Index/EntryLo0/EntryLo1/EntryHi) are built when the
// macro CP0_TLB_REGS_EN is defined; otherwise those addresses read 0.
// Handshake: no valid/ready here; every *_we/_wen/exc_valid/eret input is a
// single-cycle strobe that takes effect at the next posedge. Same-cycle writes
// merge per field with priority exception > eret/tlbr/tlbp > mtc0.
module cp0_regfile #(
  parameter int TLBNUM = 16,
  localparam int IDXW = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [7:0]      cp0_addr,
  input  logic            cp0_wen,
  input  logic [31:0]     cp0_wdata,
  output logic [31:0]     cp0_rdata,
  input  logic            exc_valid,
  input  logic [4:0]      exc_code,
  input  logic [31:0]     exc_pc,
  input  logic            exc_bd,
  input  logic [31:0]     exc_badvaddr,
  input  logic            eret,
  input  logic [5:0]      ext_int,
  output logic [31:0]     epc_out,
  output logic            int_happen,
  input  logic            tlbp_we,
  input  logic            tlbp_hit,
  input  logic [IDXW-1:0] tlbp_idx,
  input  logic            tlbr_we,
  input  logic [31:0]     tlbr_hi,
  input  logic [31:0]     tlbr_lo0,
  input  logic [31:0]     tlbr_lo1,
  output logic [IDXW-1:0] index_out,
  output logic [31:0]     entryhi_out,
  output logic [31:0]     entrylo0_out,
  output logic [31:0]     entrylo1_out
);

  localparam logic [7:0] A_INDEX   = 8'h00;
  localparam logic [7:0] A_LO0     = 8'h10;
  localparam logic [7:0] A_LO1     = 8'h18;
  localparam logic [7:0] A_BADV    = 8'h40;
  localparam logic [7:0] A_COUNT   = 8'h48;
  localparam logic [7:0] A_HI      = 8'h50;
  localparam logic [7:0] A_COMPARE = 8'h58;
  localparam logic [7:0] A_STATUS  = 8'h60;
  localparam logic [7:0] A_CAUSE   = 8'h68;
  localparam logic [7:0] A_EPC     = 8'h70;

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d, ie_q, ie_d;
  logic        bd_q, bd_d, ti_q, ti_d;
  logic [5:0]  hw_q;
  logic [1:0]  sw_q, sw_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d, badv_q, badv_d;
  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic        tick_q;

  logic [7:0]  ip;
  logic [31:0] status_rd, cause_rd;
  logic        badv_exc;

  // IP[7] shares the timer interrupt with hardware line 5.
  assign ip        = {hw_q[5] | ti_q, hw_q[4:0], sw_q};
  assign status_rd = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause_rd  = {bd_q, ti_q, 14'd0, ip, 1'b0, code_q, 2'd0};
  assign badv_exc  = exc_valid && (exc_code >= 5'd1) && (exc_code <= 5'd5);

  assign epc_out    = epc_q;
  assign int_happen = ie_q & ~exl_q & (|(ip & im_q));

  // Next-state for the core registers, exception/eret overriding mtc0 per field.
  always_comb begin
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    sw_d      = sw_q;
    code_d    = code_q;
    epc_d     = epc_q;
    badv_d    = badv_q;
    compare_d = compare_q;
    count_d   = tick_q ? count_q + 32'd1 : count_q;
    ti_d      = (count_q == compare_q) ? 1'b1 : ti_q;
    if (cp0_wen) begin
      case (cp0_addr)
        A_COUNT:   count_d = cp0_wdata;
        A_COMPARE: begin
          compare_d = cp0_wdata;
          ti_d      = 1'b0;
        end
        A_STATUS: begin
          im_d  = cp0_wdata[15:8];
          exl_d = cp0_wdata[1];
          ie_d  = cp0_wdata[0];
        end
        A_CAUSE:   sw_d  = cp0_wdata[9:8];
        A_EPC:     epc_d = cp0_wdata;
        default:   ;
      endcase
    end
    if (eret) exl_d = 1'b0;
    if (exc_valid) begin
      exl_d  = 1'b1;
      code_d = exc_code;
      epc_d  = epc_q;
      if (!exl_q) begin
        epc_d = exc_bd ? exc_pc - 32'd4 : exc_pc;
        bd_d  = exc_bd;
      end
    end
    if (badv_exc) badv_d = exc_badvaddr;
  end

  // Core register state, timer tick and interrupt line sampling.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      im_q <= '0; exl_q <= 1'b0; ie_q <= 1'b0;
      bd_q <= 1'b0; ti_q <= 1'b0; hw_q <= '0; sw_q <= '0; code_q <= '0;
      epc_q <= '0; badv_q <= '0; count_q <= '0; compare_q <= '0; tick_q <= 1'b0;
    end else begin
      im_q <= im_d; exl_q <= exl_d; ie_q <= ie_d;
      bd_q <= bd_d; ti_q <= ti_d; hw_q <= ext_int; sw_q <= sw_d; code_q <= code_d;
      epc_q <= epc_d; badv_q <= badv_d; count_q <= count_d; compare_q <= compare_d;
      tick_q <= ~tick_q;
    end
  end

`ifdef CP0_TLB_REGS_EN
  logic            idx_p_q, idx_p_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [25:0]     lo0_q, lo0_d, lo1_q, lo1_d;
  logic [18:0]     vpn2_q, vpn2_d;
  logic [7:0]      asid_q, asid_d;
  logic            tlb_exc;
  logic            unused_tlb_bits;

  assign tlb_exc         = exc_valid && (exc_code >= 5'd1) && (exc_code <= 5'd3);
  assign unused_tlb_bits = ^{tlbr_hi[12:8], tlbr_lo0[31:26], tlbr_lo1[31:26]};

  assign index_out    = idx_q;
  assign entryhi_out  = {vpn2_q, 5'd0, asid_q};
  assign entrylo0_out = {6'd0, lo0_q};
  assign entrylo1_out = {6'd0, lo1_q};

  // TLB register next-state: exception > tlbr/tlbp > mtc0.
  always_comb begin
    idx_p_d = idx_p_q;
    idx_d   = idx_q;
    lo0_d   = lo0_q;
    lo1_d   = lo1_q;
    vpn2_d  = vpn2_q;
    asid_d  = asid_q;
    if (cp0_wen) begin
      case (cp0_addr)
        A_INDEX: idx_d = cp0_wdata[IDXW-1:0];
        A_LO0:   lo0_d = cp0_wdata[25:0];
        A_LO1:   lo1_d = cp0_wdata[25:0];
        A_HI: begin
          vpn2_d = cp0_wdata[31:13];
          asid_d = cp0_wdata[7:0];
        end
        default: ;
      endcase
    end
    if (tlbp_we) begin
      idx_p_d = ~tlbp_hit;
      if (tlbp_hit) idx_d = tlbp_idx;
    end
    if (tlbr_we) begin
      vpn2_d = tlbr_hi[31:13];
      asid_d = tlbr_hi[7:0];
      lo0_d  = tlbr_lo0[25:0];
      lo1_d  = tlbr_lo1[25:0];
    end
    if (tlb_exc) vpn2_d = exc_badvaddr[31:13];
  end

  // TLB register state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      idx_p_q <= 1'b0; idx_q <= '0; lo0_q <= '0; lo1_q <= '0; vpn2_q <= '0; asid_q <= '0;
    end else begin
      idx_p_q <= idx_p_d; idx_q <= idx_d; lo0_q <= lo0_d; lo1_q <= lo1_d;
      vpn2_q <= vpn2_d; asid_q <= asid_d;
    end
  end
`else
  logic unused_tlb;
  assign unused_tlb   = ^{tlbp_we, tlbp_hit, tlbp_idx, tlbr_we, tlbr_hi, tlbr_lo0, tlbr_lo1};
  assign index_out    = '0;
  assign entryhi_out  = '0;
  assign entrylo0_out = '0;
  assign entrylo1_out = '0;
`endif

  // mfc0 read mux; returns pre-write values for registers written this cycle.
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      A_BADV:    cp0_rdata = badv_q;
      A_COUNT:   cp0_rdata = count_q;
      A_COMPARE: cp0_rdata = compare_q;
      A_STATUS:  cp0_rdata = status_rd;
      A_CAUSE:   cp0_rdata = cause_rd;
      A_EPC:     cp0_rdata = epc_q;
`ifdef CP0_TLB_REGS_EN
      A_INDEX:   cp0_rdata = {idx_p_q, {(31-IDXW){1'b0}}, idx_q};
      A_LO0:     cp0_rdata = entrylo0_out;
      A_LO1:     cp0_rdata = entrylo1_out;
      A_HI:      cp0_rdata = entryhi_out;
`endif
      default:   cp0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: scoreboard bench for cp0_regfile. A driver applies one
// request set per cycle, predicts the observable outputs from a register-image
// model and queues them; a negedge monitor pops and compares.
module tb_cp0_regfile;
  localparam int TLBNUM = 16;
  localparam int IDXW = $clog2(TLBNUM);

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]      cp0_addr = '0;
  logic            cp0_wen = 1'b0;
  logic [31:0]     cp0_wdata = '0;
  logic [31:0]     cp0_rdata;
  logic            exc_valid = 1'b0;
  logic [4:0]      exc_code = '0;
  logic [31:0]     exc_pc = '0;
  logic            exc_bd = 1'b0;
  logic [31:0]     exc_badvaddr = '0;
  logic            eret = 1'b0;
  logic [5:0]      ext_int = '0;
  logic [31:0]     epc_out;
  logic            int_happen;
  logic            tlbp_we = 1'b0;
  logic            tlbp_hit = 1'b0;
  logic [IDXW-1:0] tlbp_idx = '0;
  logic            tlbr_we = 1'b0;
  logic [31:0]     tlbr_hi = '0, tlbr_lo0 = '0, tlbr_lo1 = '0;
  logic [IDXW-1:0] index_out;
  logic [31:0]     entryhi_out, entrylo0_out, entrylo1_out;

  cp0_regfile #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .resetn(resetn), .cp0_addr(cp0_addr), .cp0_wen(cp0_wen),
    .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr),
    .eret(eret), .ext_int(ext_int), .epc_out(epc_out), .int_happen(int_happen),
    .tlbp_we(tlbp_we), .tlbp_hit(tlbp_hit), .tlbp_idx(tlbp_idx), .tlbr_we(tlbr_we),
    .tlbr_hi(tlbr_hi), .tlbr_lo0(tlbr_lo0), .tlbr_lo1(tlbr_lo1), .index_out(index_out),
    .entryhi_out(entryhi_out), .entrylo0_out(entrylo0_out), .entrylo1_out(entrylo1_out)
  );

`ifdef CP0_TLB_REGS_EN
  localparam bit TLB_ON = 1'b1;
`else
  localparam bit TLB_ON = 1'b0;
`endif

  // reference model: architectural register images
  logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare;
  logic [31:0] m_index, m_hi, m_lo0, m_lo1;
  logic [5:0]  m_hw;
  logic        m_ti, m_tick;

  function automatic logic [31:0] cause_img();
    logic [31:0] c;
    c = m_cause;
    c[30] = m_ti;
    c[15] = m_hw[5] | m_ti;
    c[14:10] = m_hw[4:0];
    return c;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a)
      8'h40: return m_badv;
      8'h48: return m_count;
      8'h58: return m_compare;
      8'h60: return m_status;
      8'h68: return cause_img();
      8'h70: return m_epc;
      8'h00: return TLB_ON ? m_index : 32'd0;
      8'h10: return TLB_ON ? m_lo0 : 32'd0;
      8'h18: return TLB_ON ? m_lo1 : 32'd0;
      8'h50: return TLB_ON ? m_hi : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_int();
    logic [31:0] c;
    c = cause_img();
    return m_status[0] && !m_status[1] && ((c[15:8] & m_status[15:8]) != 8'd0);
  endfunction

  // scoreboard
  typedef struct packed {
    logic [31:0] rd;
    logic        ih;
    logic [31:0] epc;
    logic [31:0] idx;
    logic [31:0] hi;
    logic [31:0] lo0;
    logic [31:0] lo1;
  } exp_t;
  exp_t  exp_q[$];
  string nm_q[$];
  logic  obs_on = 1'b0;
  int    n_tests = 0;
  int    n_fail = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: one popped entry per observed cycle, sampled at negedge
  always @(negedge clk) begin
    if (obs_on) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_underflow at %0t", $time);
      end else begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        cmp({nm, "/rdata"}, cp0_rdata, e.rd);
        cmp({nm, "/int_happen"}, {31'd0, int_happen}, {31'd0, e.ih});
        cmp({nm, "/epc_out"}, epc_out, e.epc);
        cmp({nm, "/index_out"}, {{(32-IDXW){1'b0}}, index_out}, e.idx);
        cmp({nm, "/entryhi_out"}, entryhi_out, e.hi);
        cmp({nm, "/entrylo0_out"}, entrylo0_out, e.lo0);
        cmp({nm, "/entrylo1_out"}, entrylo1_out, e.lo1);
      end
    end
  end

  // driver: one cycle; inputs already set by caller at posedge+1
  task automatic drive(input bit obs, input bit use_c, input logic [31:0] cval, input string nm);
    logic [31:0] n_status, n_cause, n_epc, n_badv, n_count, n_compare;
    logic [31:0] n_index, n_hi, n_lo0, n_lo1;
    logic        n_ti;
    bit          w;
    exp_t        e;
    if (obs) begin
      e.rd  = use_c ? cval : model_read(cp0_addr);
      e.ih  = model_int();
      e.epc = m_epc;
      e.idx = TLB_ON ? {{(32-IDXW){1'b0}}, m_index[IDXW-1:0]} : 32'd0;
      e.hi  = TLB_ON ? m_hi : 32'd0;
      e.lo0 = TLB_ON ? m_lo0 : 32'd0;
      e.lo1 = TLB_ON ? m_lo1 : 32'd0;
      exp_q.push_back(e);
      nm_q.push_back(nm);
    end
    obs_on = obs;
    w = cp0_wen;
    // timer
    n_count = m_tick ? m_count + 1 : m_count;
    if (w && cp0_addr == 8'h48) n_count = cp0_wdata;
    n_compare = (w && cp0_addr == 8'h58) ? cp0_wdata : m_compare;
    n_ti = (w && cp0_addr == 8'h58) ? 1'b0 : ((m_count == m_compare) ? 1'b1 : m_ti);
    // status
    n_status = m_status;
    if (w && cp0_addr == 8'h60) n_status = 32'h0040_0000 | (cp0_wdata & 32'h0000_FF03);
    if (eret) n_status[1] = 1'b0;
    if (exc_valid) n_status[1] = 1'b1;
    // cause / epc / badvaddr
    n_cause = m_cause;
    if (w && cp0_addr == 8'h68) n_cause[9:8] = cp0_wdata[9:8];
    n_epc = (w && cp0_addr == 8'h70) ? cp0_wdata : m_epc;
    n_badv = m_badv;
    if (exc_valid) begin
      n_cause[6:2] = exc_code;
      if (!m_status[1]) begin
        n_cause[31] = exc_bd;
        n_epc = exc_bd ? exc_pc - 4 : exc_pc;
      end else begin
        n_epc = m_epc;
      end
      if (exc_code inside {[5'd1:5'd5]}) n_badv = exc_badvaddr;
    end
    // tlb registers
    n_index = m_index; n_hi = m_hi; n_lo0 = m_lo0; n_lo1 = m_lo1;
    if (w && cp0_addr == 8'h00) n_index[IDXW-1:0] = cp0_wdata[IDXW-1:0];
    if (w && cp0_addr == 8'h10) n_lo0 = cp0_wdata & 32'h03FF_FFFF;
    if (w && cp0_addr == 8'h18) n_lo1 = cp0_wdata & 32'h03FF_FFFF;
    if (w && cp0_addr == 8'h50) n_hi = cp0_wdata & 32'hFFFF_E0FF;
    if (tlbp_we) begin
      n_index[31] = !tlbp_hit;
      if (tlbp_hit) n_index[IDXW-1:0] = tlbp_idx;
    end
    if (tlbr_we) begin
      n_hi = tlbr_hi & 32'hFFFF_E0FF;
      n_lo0 = tlbr_lo0 & 32'h03FF_FFFF;
      n_lo1 = tlbr_lo1 & 32'h03FF_FFFF;
    end
    if (exc_valid && exc_code inside {[5'd1:5'd3]}) n_hi[31:13] = exc_badvaddr[31:13];
    @(posedge clk);
    if (!resetn) begin
      m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_badv = 0; m_count = 0;
      m_compare = 0; m_ti = 0; m_tick = 0; m_hw = 0;
      m_index = 0; m_hi = 0; m_lo0 = 0; m_lo1 = 0;
    end else begin
      m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_badv = n_badv;
      m_count = n_count; m_compare = n_compare; m_ti = n_ti; m_tick = !m_tick;
      m_hw = ext_int;
      m_index = n_index; m_hi = n_hi; m_lo0 = n_lo0; m_lo1 = n_lo1;
    end
    #1;
    cp0_wen = 0; exc_valid = 0; eret = 0; tlbp_we = 0; tlbr_we = 0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cp0_addr = a; cp0_wdata = d; cp0_wen = 1'b1;
    drive(1'b1, 1'b0, 32'd0, "mtc0");
  endtask

  task automatic rd_c(input logic [7:0] a, input logic [31:0] v, input string nm);
    cp0_addr = a;
    drive(1'b1, 1'b1, v, nm);
  endtask

  task automatic idle(input int n, input logic [7:0] a);
    for (int i = 0; i < n; i++) begin
      cp0_addr = a;
      drive(1'b1, 1'b0, 32'd0, "idle");
    end
  endtask

  task automatic take_exc(input logic [4:0] c, input logic [31:0] pc, input logic bd,
                          input logic [31:0] bv);
    exc_valid = 1'b1; exc_code = c; exc_pc = pc; exc_bd = bd; exc_badvaddr = bv;
  endtask

  logic [7:0] addrs [10] = '{8'h00, 8'h10, 8'h18, 8'h40, 8'h48, 8'h50, 8'h58, 8'h60, 8'h68, 8'h70};

  initial begin
    m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_badv = 0; m_count = 0;
    m_compare = 0; m_ti = 0; m_tick = 0; m_hw = 0;
    m_index = 0; m_hi = 0; m_lo0 = 0; m_lo1 = 0;
    @(posedge clk); #1;
    // reset
    drive(1'b0, 1'b0, 32'd0, "reset");
    rd_c(8'h60, 32'h0040_0000, "reset_status");
    rd_c(8'h68, 32'h0, "reset_cause");
    resetn = 1'b1;
    rd_c(8'h70, 32'h0, "reset_epc");
    rd_c(8'h48, 32'h0, "reset_count");
    wr(8'h58, 32'hFFFF_FFFF);
    // exception in delay slot, then nested exception with EXL set
    take_exc(5'd4, 32'hBFC0_0100, 1'b1, 32'h1234_5671);
    cp0_addr = 8'h70;
    drive(1'b1, 1'b0, 32'd0, "exc1");
    rd_c(8'h70, 32'hBFC0_00FC, "exc1_epc");
    rd_c(8'h68, 32'h8000_0010, "exc1_cause");
    rd_c(8'h40, 32'h1234_5671, "exc1_badv");
    rd_c(8'h60, 32'h0040_0002, "exc1_status");
    take_exc(5'd12, 32'h0000_0008, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'd0, "exc2");
    rd_c(8'h70, 32'hBFC0_00FC, "exc2_epc");
    rd_c(8'h68, 32'h8000_0030, "exc2_cause");
    eret = 1'b1;
    drive(1'b1, 1'b0, 32'd0, "eret");
    // timer
    wr(8'h58, 32'd5);
    wr(8'h48, 32'd0);
    idle(14, 8'h68);
    wr(8'h60, 32'h0000_8001);
    idle(3, 8'h68);
    wr(8'h58, 32'h0000_0100);
    idle(2, 8'h68);
    // same-cycle priority
    take_exc(5'd0, 32'h8000_1000, 1'b0, 32'h0);
    eret = 1'b1;
    wr(8'h70, 32'h0000_DEAD);
    rd_c(8'h70, 32'h8000_1000, "prio_epc");
    eret = 1'b1;
    wr(8'h60, 32'h0000_0003);
    rd_c(8'h60, 32'h0040_0001, "prio_status");
    // hardware interrupt
    ext_int = 6'b000001;
    wr(8'h60, 32'h0000_0401);
    idle(2, 8'h68);
    wr(8'h60, 32'h0000_0403);
    idle(2, 8'h60);
    ext_int = 6'b0;
    // tlb registers
    tlbp_we = 1'b1; tlbp_hit = 1'b0; tlbp_idx = 4'd7;
    drive(1'b1, 1'b0, 32'd0, "tlbp");
    rd_c(8'h00, TLB_ON ? 32'h8000_0000 : 32'h0, "tlbp_index");
    tlbr_we = 1'b1; tlbr_hi = 32'hABCD_E0FF; tlbr_lo0 = 32'h0123_4567; tlbr_lo1 = 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 32'd0, "tlbr");
    rd_c(8'h50, TLB_ON ? 32'hABCD_E0FF : 32'h0, "tlbr_hi");
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cp0_addr = addrs[$urandom_range(0, 9)];
      cp0_wen = ($urandom_range(0, 2) == 0);
      cp0_wdata = $urandom();
      if ($urandom_range(0, 15) == 0)
        take_exc(5'($urandom_range(0, 12)), $urandom(), 1'($urandom_range(0, 1)), $urandom());
      eret = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) ext_int = 6'($urandom_range(0, 63));
      tlbp_we = ($urandom_range(0, 15) == 0);
      tlbp_hit = 1'($urandom_range(0, 1));
      tlbp_idx = IDXW'($urandom_range(0, TLBNUM - 1));
      tlbr_we = ($urandom_range(0, 15) == 0);
      tlbr_hi = $urandom(); tlbr_lo0 = $urandom(); tlbr_lo1 = $urandom();
      drive(1'b1, 1'b0, 32'd0, "rand");
    end
    obs_on = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
